// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the counter-based synchronous FIFO controller.
// Contents:
//   - default data/address widths and almost-flag thresholds
//   - occupancy-state enum, decoded from the count, for debug visibility
//   - helper returning the default almost_full level (DEPTH-1) for an address width
package sync_fifo_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAddrWidth = 9;
    localparam int unsigned DefAeLevel   = 1;
    localparam int unsigned DefAfLevel   = (2 ** DefAddrWidth) - 1;

    typedef enum logic [1:0] {
        OccEmpty,
        OccNormal,
        OccFull
    } occ_state_e;

    // almost_full default tracks the chosen depth rather than the package default depth.
    function automatic int unsigned def_af_level(input int unsigned addr_width);
        return (2 ** addr_width) - 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping FIFO pointer.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset, clears the pointer to 0
//   inc_i  - advance the pointer by one this cycle
//   ptr_o  - current pointer value, wraps from 2**WIDTH-1 to 0
module fifo_ptr_cnt #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q, ptr_d;

    // Depth is a power of two, so natural overflow gives the wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Counter-based synchronous FIFO controller driving both ports of an external
// dual-port RAM whose read data is registered inside the RAM.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   push, push_data             - client write request and word
//   pop                         - client read request
//   pop_data, pop_valid         - read word and its one-cycle valid strobe
//   full, empty                 - count == DEPTH / count == 0
//   almost_full, almost_empty   - count >= AF_LEVEL / count <= AE_LEVEL
//   count                       - occupancy, 0..DEPTH
//   overflow, underflow         - one-cycle pulses after a rejected push / pop
//   ram_w_enable/addr/data      - RAM write port
//   ram_r_enable/addr, ram_r_data - RAM read port
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned AF_LEVEL   = def_af_level(ADDR_WIDTH),
    parameter int unsigned AE_LEVEL   = DefAeLevel
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_w_enable,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic                  ram_r_enable,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_r_data
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW  = ADDR_WIDTH + 1;

    logic [CntW-1:0]       count_q, count_d;
    logic                  pop_valid_q, overflow_q, underflow_q;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  push_ok, pop_ok;
    occ_state_e            occ_state;

    // Occupancy state is purely a decode of the count; no separate state register.
    always_comb begin
        if (count_q == CntW'(0)) begin
            occ_state = OccEmpty;
        end else if (count_q == CntW'(Depth)) begin
            occ_state = OccFull;
        end else begin
            occ_state = OccNormal;
        end
    end

    assign full         = (occ_state == OccFull);
    assign empty        = (occ_state == OccEmpty);
    assign almost_full  = (count_q >= CntW'(AF_LEVEL));
    assign almost_empty = (count_q <= CntW'(AE_LEVEL));
    assign count        = count_q;

    // Flags are from registered state only, so a simultaneous pop never unblocks a
    // push at full and a simultaneous push never unblocks a pop at empty. Gating with
    // rst_n keeps the RAM idle while reset is held.
    assign push_ok = push & ~full & rst_n;
    assign pop_ok  = pop & ~empty & rst_n;

    fifo_ptr_cnt #(
        .WIDTH(ADDR_WIDTH)
    ) u_wr_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc_i(push_ok),
        .ptr_o(wr_ptr)
    );

    fifo_ptr_cnt #(
        .WIDTH(ADDR_WIDTH)
    ) u_rd_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc_i(pop_ok),
        .ptr_o(rd_ptr)
    );

    assign ram_w_enable = push_ok;
    assign ram_w_addr   = wr_ptr;
    assign ram_w_data   = push_data;
    assign ram_r_enable = pop_ok;
    assign ram_r_addr   = rd_ptr;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_valid_q <= pop_ok;
            overflow_q  <= push & full;
            underflow_q <= pop & empty;
        end
    end

    // RAM registers its read data, so it lines up with pop_valid_q.
    assign pop_data  = ram_r_data;
    assign pop_valid = pop_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 2;
    localparam int          DEPTH = 4;
    localparam int          AF    = 3;
    localparam int          AE    = 1;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic          ram_w_enable, ram_r_enable;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic [DW-1:0] ram_w_data, ram_r_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int            m_cnt;
    logic [AW-1:0] m_wp, m_rp;
    logic          m_ovf, m_unf, m_pv;
    logic [DW-1:0] m_fifo[$];
    logic [DW-1:0] exp_q[$];

    sync_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .ram_w_enable(ram_w_enable),
        .ram_w_addr  (ram_w_addr),
        .ram_w_data  (ram_w_data),
        .ram_r_enable(ram_r_enable),
        .ram_r_addr  (ram_r_addr),
        .ram_r_data  (ram_r_data)
    );

    // Behavioural dual-port RAM with registered read data
    logic [DW-1:0] mem[DEPTH];
    always @(posedge clk) begin
        if (ram_w_enable) mem[ram_w_addr] <= ram_w_data;
        if (ram_r_enable) ram_r_data <= mem[ram_r_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: each valid word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && pop_valid) begin
            check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                check_eq("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic model_reset();
        m_cnt = 0;
        m_wp  = '0;
        m_rp  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_pv  = 1'b0;
        m_fifo.delete();
        exp_q.delete();
    endtask

    task automatic check_flags();
        check_eq("count", 32'(count), 32'(m_cnt));
        check_eq("full", 32'(full), 32'(m_cnt == DEPTH));
        check_eq("empty", 32'(empty), 32'(m_cnt == 0));
        check_eq("almost_full", 32'(almost_full), 32'(m_cnt >= AF));
        check_eq("almost_empty", 32'(almost_empty), 32'(m_cnt <= AE));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_unf));
        check_eq("pop_valid", 32'(pop_valid), 32'(m_pv));
    endtask

    // One clock cycle: drive at negedge, check, update model, wait for next negedge.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic r);
        logic pok, rok;
        push      = p;
        push_data = d;
        pop       = r;
        #1;
        pok = p && (m_cnt < DEPTH);
        rok = r && (m_cnt != 0);
        check_flags();
        check_eq("ram_w_enable", 32'(ram_w_enable), 32'(pok));
        check_eq("ram_r_enable", 32'(ram_r_enable), 32'(rok));
        if (pok) begin
            check_eq("ram_w_addr", 32'(ram_w_addr), 32'(m_wp));
            check_eq("ram_w_data", 32'(ram_w_data), 32'(d));
        end
        if (rok) begin
            check_eq("ram_r_addr", 32'(ram_r_addr), 32'(m_rp));
        end
        m_ovf = p && (m_cnt == DEPTH);
        m_unf = r && (m_cnt == 0);
        m_pv  = rok;
        if (rok) begin
            exp_q.push_back(m_fifo.pop_front());
            m_rp = m_rp + 1'b1;
        end
        if (pok) begin
            m_fifo.push_back(d);
            m_wp = m_wp + 1'b1;
        end
        m_cnt = m_cnt + (pok ? 1 : 0) - (rok ? 1 : 0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_count"}, 32'(count), 32'(0));
        check_eq({tag, "_empty"}, 32'(empty), 32'(1));
        check_eq({tag, "_almost_empty"}, 32'(almost_empty), 32'(1));
        check_eq({tag, "_full"}, 32'(full), 32'(0));
        check_eq({tag, "_almost_full"}, 32'(almost_full), 32'(0));
        check_eq({tag, "_pop_valid"}, 32'(pop_valid), 32'(0));
        check_eq({tag, "_overflow"}, 32'(overflow), 32'(0));
        check_eq({tag, "_underflow"}, 32'(underflow), 32'(0));
        check_eq({tag, "_ram_w_enable"}, 32'(ram_w_enable), 32'(0));
        check_eq({tag, "_ram_r_enable"}, 32'(ram_r_enable), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        push      = 1'b1;
        push_data = 8'h00;
        pop       = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        // Requests held during reset must not reach the RAM.
        check_reset_outputs("reset");
        push  = 1'b0;
        pop   = 1'b0;
        rst_n = 1'b1;
        idle(1);

        // Fill then overflow
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA1 + i), 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        idle(2);

        // Drain back-to-back
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        idle(2);

        // Simultaneous push/pop at count 2
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hB1 + i), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        idle(2);

        // Underflow with a concurrent push
        step(1'b1, 8'h55, 1'b1);
        idle(1);
        step(1'b0, '0, 1'b1);
        idle(2);

        // Wrap-around stream, occupancy at most 1
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), (i > 0));
        step(1'b0, '0, 1'b1);
        idle(2);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        while (m_cnt != 0) step(1'b0, '0, 1'b1);
        idle(2);

        // Async reset mid-operation: bring count to 3, present a pop, drop reset
        // between edges before the pop can be clocked.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE1 + i), 1'b0);
        push = 1'b0;
        pop  = 1'b1;
        #1;
        check_eq("pre_rst_count", 32'(count), 32'(3));
        check_eq("pre_rst_ram_r_enable", 32'(ram_r_enable), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_eq("rst_no_pop_valid", 32'(pop_valid), 32'(0));
        @(negedge clk);
        pop   = 1'b0;
        model_reset();
        rst_n = 1'b1;
        // Pointers restart from 0 after reset.
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, '0, 1'b1);
        idle(2);

        check_eq("sb_empty_at_end", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
